hbm_read_engine: RTL and testbench

Strided HBM burst reader that sits directly downstream of `hbm_write` in the SGD data path. Once `hbm_write` has staged the weaved sample data into an HBM pseudo-channel, this block replays it: it issues AXI read bursts at `base + row*stride`, optionally over several passes (epochs), and delivers the returned beats in order on a 256-bit stream to the SGD engine. Outstanding reads are limited by free space in an internal FIFO, so the block never drops data under downstream back-pressure.

---
 rtl/hbm_read_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_hbm_read_engine.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_read_engine.sv
`timescale 1ns / 1ps
// hbm_read_engine: strided HBM burst reader.
// Replays rows staged by hbm_write. It issues one AXI INCR burst of BURST_LEN beats per row at
// base + row*stride, repeats the sweep number_of_passes times, and streams the returned beats
// in order on a DATA_W-bit AXI-Stream port. A new AR is raised only when the internal FIFO has
// room reserved for its whole burst, so downstream back-pressure never drops data.
//
// Ports:
//   hbm_clk, hbm_aresetn        clock, asynchronous active-low reset
//   start                       one-cycle pulse, accepted only while idle
//   hbm_addr_base, araddr_stride, number_of_rows, number_of_passes   run configuration
//   busy, hbm_read_done         run status, done is a one-cycle pulse
//   rresp_err                   sticky read-response error flag
//   m_axi_AR*, m_axi_R*         AXI4 read address / read data channels to HBM
//   m_axis_*                    output beat stream; last marks the final beat of each row
//
// Optional feature: define HBM_READ_RRESP_CHECK_EN to check RRESP and RLAST placement.
// Without it rresp_err is tied to 0.
module hbm_read_engine #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned ADDR_W     = 33
) (
    input  logic              hbm_clk,
    input  logic              hbm_aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] hbm_addr_base,
    input  logic [31:0]       araddr_stride,
    input  logic [31:0]       number_of_rows,
    input  logic [31:0]       number_of_passes,
    output logic              busy,
    output logic              hbm_read_done,
    output logic              rresp_err,
    output logic              m_axi_ARVALID,
    output logic [ADDR_W-1:0] m_axi_ARADDR,
    output logic [5:0]        m_axi_ARID,
    output logic [7:0]        m_axi_ARLEN,
    output logic [2:0]        m_axi_ARSIZE,
    output logic [1:0]        m_axi_ARBURST,
    input  logic              m_axi_ARREADY,
    input  logic              m_axi_RVALID,
    input  logic [DATA_W-1:0] m_axi_RDATA,
    input  logic              m_axi_RLAST,
    input  logic [1:0]        m_axi_RRESP,
    input  logic [5:0]        m_axi_RID,
    output logic              m_axi_RREADY,
    output logic              m_axis_valid,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_last,
    input  logic              m_axis_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, acc_q, araddr_q;
    logic [31:0]         stride_q, rows_q, passes_q, row_q, pass_q;
    logic                all_loaded_q, arvalid_q;
    logic [CW-1:0]       credit_q, credit_d;
    logic [63:0]         beats_out_q, beats_out_d, total_beats;
    logic [BW-1:0]       out_beat_q;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PW:0]         wr_ptr_q, rd_ptr_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;

    logic start_acc, ar_hs, r_hs, pop, cfg_zero, ar_slot_free, may_issue, ar_load;
    logic last_row, last_pass, mem_empty, out_load, bypass, mem_wr;

    assign start_acc    = (state_q == StIdle) && start;
    assign ar_hs        = arvalid_q && m_axi_ARREADY;
    assign r_hs         = m_axi_RVALID && m_axi_RREADY;
    assign pop          = out_valid_q && m_axis_ready;
    assign cfg_zero     = (rows_q == 32'd0) || (passes_q == 32'd0);
    assign last_row     = row_q == rows_q - 32'd1;
    assign last_pass    = pass_q == passes_q - 32'd1;
    assign total_beats  = 64'(rows_q) * 64'(passes_q) * 64'(BURST_LEN);
    assign beats_out_d  = beats_out_q + (pop ? 64'd1 : 64'd0);

    // Credit counts free FIFO slots not yet promised to an issued burst. An R beat moves a slot
    // from reserved to occupied, so only AR handshakes and output pops change it.
    assign credit_d     = credit_q - (ar_hs ? CW'(BURST_LEN) : CW'(0)) + (pop ? CW'(1) : CW'(0));
    assign ar_slot_free = !arvalid_q || ar_hs;
    assign may_issue    = ((state_q == StLoad) && !cfg_zero) || (state_q == StIssue);
    assign ar_load      = may_issue && ar_slot_free && !all_loaded_q &&
                          (credit_d >= CW'(BURST_LEN));

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = cfg_zero ? StDone : StIssue;
            StIssue: if (all_loaded_q && ar_slot_free) state_d = StDrain;
            StDrain: if (beats_out_d == total_beats) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Configuration is captured with the accepted start so LOAD can already present row 0.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            base_q       <= '0;
            stride_q     <= '0;
            rows_q       <= '0;
            passes_q     <= '0;
            row_q        <= '0;
            pass_q       <= '0;
            acc_q        <= '0;
            all_loaded_q <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            credit_q     <= CW'(FIFO_DEPTH);
            beats_out_q  <= '0;
            out_beat_q   <= '0;
        end else begin
            credit_q <= credit_d;
            if (start_acc) begin
                base_q       <= hbm_addr_base;
                stride_q     <= araddr_stride;
                rows_q       <= number_of_rows;
                passes_q     <= number_of_passes;
                row_q        <= '0;
                pass_q       <= '0;
                acc_q        <= hbm_addr_base;
                all_loaded_q <= 1'b0;
                beats_out_q  <= '0;
                out_beat_q   <= '0;
            end else begin
                beats_out_q <= beats_out_d;
                if (pop) begin
                    out_beat_q <= (out_beat_q == BW'(BURST_LEN - 1)) ? '0 : out_beat_q + BW'(1);
                end
            end
            if (ar_load) begin
                arvalid_q <= 1'b1;
                araddr_q  <= acc_q;
                if (last_row) begin
                    row_q <= '0;
                    acc_q <= base_q;
                    if (last_pass) all_loaded_q <= 1'b1;
                    else           pass_q <= pass_q + 32'd1;
                end else begin
                    row_q <= row_q + 32'd1;
                    acc_q <= acc_q + ADDR_W'(stride_q);
                end
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
        end
    end

    // Beat FIFO with a registered head; an R beat bypasses storage when the FIFO is empty.
    assign mem_empty = wr_ptr_q == rd_ptr_q;
    assign out_load  = !out_valid_q || pop;
    assign bypass    = out_load && mem_empty;
    assign mem_wr    = r_hs && !bypass;

    always_ff @(posedge hbm_clk) begin
        if (mem_wr) mem[wr_ptr_q[PW-1:0]] <= m_axi_RDATA;
    end

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (out_load) begin
                if (!mem_empty) begin
                    out_data_q  <= mem[rd_ptr_q[PW-1:0]];
                    out_valid_q <= 1'b1;
                    rd_ptr_q    <= rd_ptr_q + 1'b1;
                end else if (r_hs) begin
                    out_data_q  <= m_axi_RDATA;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef HBM_READ_RRESP_CHECK_EN
    logic [BW-1:0] r_beat_q;
    logic          err_q;
    logic          unused_rid;
    assign unused_rid = ^m_axi_RID;

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_beat_q <= '0;
            err_q    <= 1'b0;
        end else if (start_acc) begin
            r_beat_q <= '0;
            err_q    <= 1'b0;
        end else if (r_hs) begin
            if ((m_axi_RRESP != 2'b00) || (m_axi_RLAST && (r_beat_q != BW'(BURST_LEN - 1)))) begin
                err_q <= 1'b1;
            end
            r_beat_q <= (r_beat_q == BW'(BURST_LEN - 1)) ? '0 : r_beat_q + BW'(1);
        end
    end
    assign rresp_err = err_q;
`else
    logic unused_rsp;
    assign unused_rsp = ^{m_axi_RID, m_axi_RRESP, m_axi_RLAST};
    assign rresp_err  = 1'b0;
`endif

    assign busy          = state_q != StIdle;
    assign hbm_read_done = state_q == StDone;
    assign m_axi_RREADY  = busy;
    assign m_axi_ARVALID = arvalid_q;
    assign m_axi_ARADDR  = araddr_q;
    assign m_axi_ARID    = 6'd0;
    assign m_axi_ARLEN   = arvalid_q ? 8'(BURST_LEN - 1) : 8'd0;
    assign m_axi_ARSIZE  = 3'b101;
    assign m_axi_ARBURST = 2'b01;
    assign m_axis_valid  = out_valid_q;
    assign m_axis_data   = out_data_q;
    assign m_axis_last   = out_valid_q && (out_beat_q == BW'(BURST_LEN - 1));

endmodule

// File: tb/tb_hbm_read_engine.sv
`timescale 1ns / 1ps
// Directed bench for hbm_read_engine with an in-order AXI read responder and a beat scoreboard.
module tb_hbm_read_engine;

    localparam int BL = 16;

    logic         hbm_clk = 1'b0;
    logic         hbm_aresetn = 1'b0;
    logic         start = 1'b0;
    logic [32:0]  hbm_addr_base = '0;
    logic [31:0]  araddr_stride = '0, number_of_rows = '0, number_of_passes = '0;
    logic         busy, hbm_read_done, rresp_err;
    logic         m_axi_ARVALID, m_axi_ARREADY = 1'b1;
    logic [32:0]  m_axi_ARADDR;
    logic [5:0]   m_axi_ARID;
    logic [7:0]   m_axi_ARLEN;
    logic [2:0]   m_axi_ARSIZE;
    logic [1:0]   m_axi_ARBURST;
    logic         m_axi_RVALID = 1'b0, m_axi_RLAST = 1'b0, m_axi_RREADY;
    logic [255:0] m_axi_RDATA = '0;
    logic [1:0]   m_axi_RRESP = 2'b00;
    logic [5:0]   m_axi_RID = 6'd0;
    logic         m_axis_valid, m_axis_last, m_axis_ready = 1'b1;
    logic [255:0] m_axis_data;

    hbm_read_engine dut (
        .hbm_clk(hbm_clk), .hbm_aresetn(hbm_aresetn), .start(start),
        .hbm_addr_base(hbm_addr_base), .araddr_stride(araddr_stride),
        .number_of_rows(number_of_rows), .number_of_passes(number_of_passes),
        .busy(busy), .hbm_read_done(hbm_read_done), .rresp_err(rresp_err),
        .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARID(m_axi_ARID),
        .m_axi_ARLEN(m_axi_ARLEN), .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST),
        .m_axi_ARREADY(m_axi_ARREADY), .m_axi_RVALID(m_axi_RVALID), .m_axi_RDATA(m_axi_RDATA),
        .m_axi_RLAST(m_axi_RLAST), .m_axi_RRESP(m_axi_RRESP), .m_axi_RID(m_axi_RID),
        .m_axi_RREADY(m_axi_RREADY), .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready)
    );

    always #5 hbm_clk = ~hbm_clk;

    int cyc = 0;
    always @(posedge hbm_clk) cyc <= cyc + 1;

    int evals = 0, fails = 0;
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [32:0] a, input int b);
        return {191'd0, a, 32'(b)};
    endfunction

    logic [32:0]  exp_ar[$];
    logic [255:0] exp_data[$];
    logic         exp_last[$];
    logic [32:0]  rsp_q[$];

    task automatic push_row(input logic [32:0] a);
        exp_ar.push_back(a);
        for (int b = 0; b < BL; b++) begin
            exp_data.push_back(mk(a, b));
            exp_last.push_back(b == BL - 1);
        end
    endtask

    // AXI read responder plus AR checker: beats follow the AR order with no gaps.
    int   ar_cnt = 0, ar_mark = 0, first_ar_cyc = 0, rbeat = 0, gbeat = 0;
    logic inject = 1'b0;
    initial begin
        logic ar_hs, r_hs;
        logic [32:0] ar_a;
        forever begin
            @(negedge hbm_clk);
            ar_hs = hbm_aresetn && m_axi_ARVALID && m_axi_ARREADY;
            r_hs  = hbm_aresetn && m_axi_RVALID && m_axi_RREADY;
            ar_a  = m_axi_ARADDR;
            if (ar_hs) begin
                if (ar_cnt == ar_mark) first_ar_cyc = cyc;
                ar_cnt++;
                chk("ar_expected", exp_ar.size() != 0, 1'b1);
                if (exp_ar.size() != 0) chk("araddr", ar_a, exp_ar.pop_front());
                chk("arlen", m_axi_ARLEN, 8'd15);
            end
            @(posedge hbm_clk);
            #1;
            if (!hbm_aresetn) begin
                rsp_q.delete();
                rbeat = 0;
            end else begin
                if (r_hs) begin
                    rbeat++;
                    gbeat++;
                    if (rbeat == BL) begin
                        void'(rsp_q.pop_front());
                        rbeat = 0;
                    end
                end
                if (ar_hs) rsp_q.push_back(ar_a);
            end
            if (rsp_q.size() != 0) begin
                m_axi_RVALID = 1'b1;
                m_axi_RDATA  = mk(rsp_q[0], rbeat);
                m_axi_RLAST  = (rbeat == BL - 1);
                m_axi_RRESP  = (inject && gbeat == 5) ? 2'b10 : 2'b00;
            end else begin
                m_axi_RVALID = 1'b0;
                m_axi_RLAST  = 1'b0;
                m_axi_RRESP  = 2'b00;
            end
        end
    end

    // Output scoreboard, stall-hold check and done monitor.
    int   out_cnt = 0, last_pop_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic stall_q = 1'b0;
    logic [255:0] held = '0;
    initial begin
        forever begin
            @(negedge hbm_clk);
            if (hbm_aresetn && m_axis_valid && m_axis_ready) begin
                chk("beat_expected", exp_data.size() != 0, 1'b1);
                if (exp_data.size() != 0) begin
                    chk("axis_data", m_axis_data, exp_data.pop_front());
                    chk("axis_last", m_axis_last, exp_last.pop_front());
                end
                out_cnt++;
                last_pop_cyc = cyc;
            end
            if (hbm_aresetn && stall_q) begin
                chk("hold_valid", m_axis_valid, 1'b1);
                chk("hold_data", m_axis_data, held);
            end
            stall_q = hbm_aresetn && m_axis_valid && !m_axis_ready;
            held    = m_axis_data;
            if (hbm_aresetn && hbm_read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int start_cyc = 0, out0 = 0, d0 = 0;

    task automatic do_start();
        @(posedge hbm_clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge hbm_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic arm();
        ar_mark = ar_cnt;
        out0 = out_cnt;
        d0 = done_cnt;
        gbeat = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt <= d0; i++) @(posedge hbm_clk);
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic cfg(input logic [32:0] b, input logic [31:0] s, input logic [31:0] r,
                       input logic [31:0] p);
        hbm_addr_base = b;
        araddr_stride = s;
        number_of_rows = r;
        number_of_passes = p;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_arvalid"}, m_axi_ARVALID, 1'b0);
        chk({tag, "_araddr"}, m_axi_ARADDR, 33'd0);
        chk({tag, "_arlen"}, m_axi_ARLEN, 8'd0);
        chk({tag, "_rready"}, m_axi_RREADY, 1'b0);
        chk({tag, "_valid"}, m_axis_valid, 1'b0);
        chk({tag, "_data"}, m_axis_data, 256'd0);
        chk({tag, "_last"}, m_axis_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, hbm_read_done, 1'b0);
        chk({tag, "_err"}, rresp_err, 1'b0);
    endtask

    task automatic basic_run(input string tag);
        cfg(33'h080000000, 32'd5120, 32'd4, 32'd1);
        push_row(33'h080000000);
        push_row(33'h080001400);
        push_row(33'h080002800);
        push_row(33'h080003C00);
        arm();
        do_start();
        wait_done(600);
        chk({tag, "_ar_latency"}, first_ar_cyc - start_cyc, 2);
        chk({tag, "_ar_count"}, ar_cnt - ar_mark, 4);
        chk({tag, "_beats"}, out_cnt - out0, 64);
        chk({tag, "_done_latency"}, done_cyc - last_pop_cyc, 1);
        chk({tag, "_left"}, exp_data.size(), 0);
        @(negedge hbm_clk);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    logic exp_err;

    initial begin
`ifdef HBM_READ_RRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(posedge hbm_clk);
        #1;
        check_zero_outputs("reset");
        hbm_aresetn = 1'b1;

        basic_run("basic");

        // Back-pressure: six rows, but only four bursts fit before the consumer drains.
        @(posedge hbm_clk);
        #1;
        m_axis_ready = 1'b0;
        cfg(33'h080000000, 32'd5120, 32'd6, 32'd1);
        push_row(33'h080000000);
        push_row(33'h080001400);
        push_row(33'h080002800);
        push_row(33'h080003C00);
        push_row(33'h080005000);
        push_row(33'h080006400);
        arm();
        do_start();
        repeat (200) @(posedge hbm_clk);
        chk("bp_outstanding", ar_cnt - ar_mark, 4);
        chk("bp_no_beats", out_cnt - out0, 0);
        @(negedge hbm_clk);
        chk("bp_valid", m_axis_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        @(posedge hbm_clk);
        #1;
        m_axis_ready = 1'b1;
        wait_done(600);
        chk("bp_ar_count", ar_cnt - ar_mark, 6);
        chk("bp_beats", out_cnt - out0, 96);
        chk("bp_left", exp_data.size(), 0);

        // Multi-pass with address wrap at 2^33, plus a start pulse while busy.
        cfg(33'h1FFFFFF80, 32'd64, 32'd3, 32'd3);
        for (int p = 0; p < 3; p++) begin
            push_row(33'h1FFFFFF80);
            push_row(33'h1FFFFFFC0);
            push_row(33'h000000000);
        end
        arm();
        do_start();
        repeat (5) @(posedge hbm_clk);
        #1;
        number_of_rows = 32'd0;
        start = 1'b1;
        @(negedge hbm_clk);
        chk("mp_busy_at_restart", busy, 1'b1);
        @(posedge hbm_clk);
        #1;
        start = 1'b0;
        wait_done(800);
        repeat (10) @(posedge hbm_clk);
        chk("mp_single_done", done_cnt - d0, 1);
        chk("mp_ar_count", ar_cnt - ar_mark, 9);
        chk("mp_beats", out_cnt - out0, 144);
        chk("mp_left", exp_data.size(), 0);

        // Zero rows, then zero passes.
        cfg(33'h080000000, 32'd5120, 32'd0, 32'd1);
        arm();
        do_start();
        wait_done(20);
        chk("zr_done_latency", done_cyc - start_cyc, 2);
        chk("zr_no_ar", ar_cnt - ar_mark, 0);
        cfg(33'h080000000, 32'd5120, 32'd2, 32'd0);
        arm();
        do_start();
        wait_done(20);
        chk("zp_done_latency", done_cyc - start_cyc, 2);
        chk("zp_no_ar", ar_cnt - ar_mark, 0);

        // RRESP error on beat 5 of a single row.
        cfg(33'h000000040, 32'd0, 32'd1, 32'd1);
        push_row(33'h000000040);
        arm();
        inject = 1'b1;
        do_start();
        wait_done(200);
        chk("err_at_done", rresp_err, exp_err);
        chk("err_beats", out_cnt - out0, 16);
        inject = 1'b0;
        @(negedge hbm_clk);
        chk("err_sticky_idle", rresp_err, exp_err);
        cfg(33'h000000040, 32'd0, 32'd0, 32'd1);
        arm();
        do_start();
        @(negedge hbm_clk);
        chk("err_cleared", rresp_err, 1'b0);
        wait_done(20);

        // Reset in the middle of a long sweep.
        cfg(33'h000000000, 32'd32, 32'd100, 32'd1);
        for (int r = 0; r < 10; r++) push_row(33'(r * 32));
        arm();
        do_start();
        for (int i = 0; i < 200 && ar_cnt - ar_mark < 3; i++) @(posedge hbm_clk);
        chk("rst_reached_issue", (ar_cnt - ar_mark) >= 3, 1'b1);
        @(negedge hbm_clk);
        chk("rst_busy_before", busy, 1'b1);
        #2;
        hbm_aresetn = 1'b0;
        #1;
        check_zero_outputs("midrst");
        exp_ar.delete();
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(posedge hbm_clk);
        #1;
        hbm_aresetn = 1'b1;
        basic_run("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
